// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared FSM encoding and select/direction constants for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, DONE} state_e;
  localparam logic SEL_D = 1'b0;
  localparam logic SEL_I = 1'b1;
  localparam logic MEM_RW_READ = 1'b0;
  localparam logic MEM_RW_WRITE = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// mem_arb_watchdog: counts response-wait cycles and flags expiry after TIMEOUT cycles
module mem_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serializes fetch and data requests onto one memory port, data first
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_re,
  input  logic [DATA_W/8-1:0]   d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  stall,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_rw,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [DATA_W-1:0]     mem_req_wdata,
  output logic [DATA_W/8-1:0]   mem_req_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_resp_data,
  output logic                  mem_err
);
  localparam int MASK_W = DATA_W / 8;
  state_e state_q, state_d;
  logic i_pend_q, i_pend_d, d_pend_q, d_pend_d, sel_q, sel_d, err_q, err_d;
  logic [ADDR_W-1:0] i_addr_q, i_addr_d, d_addr_q, d_addr_d;
  logic [DATA_W-1:0] d_wdata_q, d_wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic [MASK_W-1:0] d_we_q, d_we_d;
  logic req, sel, wr, wd_clr, wd_en, wd_exp;
  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk),
    .reset(reset),
    .clr_i(wd_clr),
    .en_i(wd_en),
    .expired_o(wd_exp)
  );
  always_comb begin
    req = i_re | d_re | (|d_we);
    sel = d_pend_q ? SEL_D : SEL_I;
    wr = (sel == SEL_D) && (|d_we_q);
    state_d = state_q;
    i_pend_d = i_pend_q;
    d_pend_d = d_pend_q;
    sel_d = sel_q;
    err_d = err_q;
    i_addr_d = i_addr_q;
    d_addr_d = d_addr_q;
    d_wdata_d = d_wdata_q;
    d_we_d = d_we_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    wd_clr = 1'b0;
    wd_en = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        i_pend_d = i_re;
        d_pend_d = d_re | (|d_we);
        i_addr_d = i_addr;
        d_addr_d = d_addr;
        d_wdata_d = d_wdata;
        d_we_d = d_we;
        state_d = ISSUE;
      end
      ISSUE: if (mem_req_ready) begin
        if (wr) begin
          d_pend_d = 1'b0;
          state_d = i_pend_q ? ISSUE : DONE;
        end else begin
          sel_d = sel;
          wd_clr = 1'b1;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        wd_en = 1'b1;
        if (mem_resp_valid || wd_exp) begin
          if (mem_resp_valid && sel_q == SEL_D) d_rdata_d = mem_resp_data;
          if (mem_resp_valid && sel_q == SEL_I) i_rdata_d = mem_resp_data;
          if (!mem_resp_valid) err_d = 1'b1;
          if (sel_q == SEL_D) d_pend_d = 1'b0;
          else i_pend_d = 1'b0;
          state_d = ((sel_q == SEL_D) ? i_pend_q : d_pend_q) ? ISSUE : DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      i_pend_q <= 1'b0;
      d_pend_q <= 1'b0;
      sel_q <= SEL_D;
      err_q <= 1'b0;
      i_addr_q <= '0;
      d_addr_q <= '0;
      d_wdata_q <= '0;
      d_we_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      i_pend_q <= i_pend_d;
      d_pend_q <= d_pend_d;
      sel_q <= sel_d;
      err_q <= err_d;
      i_addr_q <= i_addr_d;
      d_addr_q <= d_addr_d;
      d_wdata_q <= d_wdata_d;
      d_we_q <= d_we_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end
  always_comb begin
    mem_req_valid = state_q == ISSUE;
    mem_req_rw = (mem_req_valid && wr) ? MEM_RW_WRITE : MEM_RW_READ;
    mem_req_addr = mem_req_valid ? ((sel == SEL_D) ? d_addr_q : i_addr_q) : '0;
    mem_req_wdata = (mem_req_valid && wr) ? d_wdata_q : '0;
    mem_req_wmask = (mem_req_valid && wr) ? d_we_q : '0;
    stall = !((state_q == IDLE && !req) || state_q == DONE);
    i_rdata = i_rdata_q;
    d_rdata = d_rdata_q;
    mem_err = err_q;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one backend memory port between the core's instruction-fetch port and data port. It sits between the pipeline and the unified memory model. It captures both requests of a pipeline step, serializes them onto the memory port (data first), and holds the core's stall input high until both are serviced. Read data is registered and held stable for the core, and a watchdog flags responses that never arrive.

Parameters:
ADDR_W, 32, address width for both core ports and the memory port
DATA_W, 32, data width; MASK_W = DATA_W/8 byte enables
TIMEOUT, 255, maximum cycles in WAIT_RESP before mem_err is set (≥1)

Ports:
clk  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset; reset==0 at a rising edge resets the block
i_re  in  1  fetch request for this step
i_addr  in  ADDR_W  fetch address
i_rdata  out  DATA_W  fetched instruction, registered, held until the next fetch completes
d_re  in  1  data read request for this step
d_we  in  MASK_W  data byte write enables; nonzero means write, and write takes precedence over d_re
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, registered, held until the next data read completes
stall  out  1  to core; 1 = pipeline must hold all step inputs
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_rw  out  1  1 = write, 0 = read
mem_req_addr  out  ADDR_W  request address
mem_req_wdata  out  DATA_W  write data
mem_req_wmask  out  MASK_W  write byte mask; 0 on reads
mem_resp_valid  in  1  read response valid
mem_resp_data  in  DATA_W  read response data
mem_err  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset values: stall=0, i_rdata=0, d_rdata=0, mem_req_valid=0, mem_req_rw=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wmask=0, mem_err=0. The FSM goes to IDLE and the pending flags clear.
- Reset mid-transaction abandons the transaction, with no retry. A mem_resp_valid arriving after reset while in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT_RESP, DONE.
- IDLE, request capture:
  - If (i_re | d_re | |d_we) is seen, latch i_pend and d_pend plus all addresses and data.
  - stall is combinationally 1 in that same cycle.
  - Next state is ISSUE.
  - With no request, stay in IDLE with stall=0.
- ISSUE:
  - Select d_pend first; otherwise i_pend.
  - Drive mem_req_valid=1 with the selected fields. They stay stable until mem_req_valid & mem_req_ready.
  - On a write handshake: clear d_pend, and the write is complete with no response expected.
  - On a read handshake: go to WAIT_RESP.
  - After a completed write: if i_pend, stay in ISSUE; else go to DONE.
- WAIT_RESP:
  - mem_req_valid=0 and the watchdog counts.
  - On mem_resp_valid, load mem_resp_data into d_rdata or i_rdata (per the serviced port) and clear that pending flag.
  - Then go to ISSUE if any pending flag remains, else to DONE.
- Watchdog:
  - Counter clears on entry to WAIT_RESP.
  - If TIMEOUT cycles elapse without a response, set mem_err=1, drop the request, leave its rdata unchanged, and continue as if it had completed. The core is never deadlocked.
- DONE: stall=0 for exactly one cycle; the core advances. Next state is IDLE, and new requests are captured in the following cycle.
- stall=1 in every state except IDLE-without-request and DONE.
- A mem_resp_valid outside WAIT_RESP is ignored. The memory guarantees ≥1 cycle between handshake and response.
- Minimum latency:
  - Single read: capture (cycle 0), handshake (cycle 1), response (cycle 2), DONE (cycle 3).
  - Store plus fetch: 5 cycles with zero-wait memory.
- Core inputs are sampled only in IDLE. Changes while stall=1 have no effect.
- Ordering: data before fetch, always, so a store to an address fetched in the same step is visible to that fetch.

Decomposition:
- Shared package mem_arb_pkg:
  - FSM state encoding (2 bits)
  - port-select constants SEL_D, SEL_I
  - MEM_RW_READ and MEM_RW_WRITE
- One sub-module, mem_arb_watchdog: a counter sized $clog2(TIMEOUT+1) with clear/enable inputs and an expired output.
- The FSM, request latches and response registers stay in the top module.

Test Plan:
- Fetch-only, zero-wait memory: i_re=1, i_addr=0x100, resp 0x00000013 → one read at 0x100, i_rdata=0x00000013, stall high 3 cycles, DONE pulse in cycle 3.
- Store plus fetch: d_we=4'b0011, d_addr=0x2000, d_wdata=0xDEADBEEF, i_re=1, i_addr=0x104 → first handshake write with wmask=0011 at 0x2000, then a read at 0x104; d_rdata unchanged.
- Backpressure: mem_req_ready held low 4 cycles on a load to 0x3000 → mem_req_valid, addr and rw stay stable all 4 cycles; after the response 0x12345678, d_rdata=0x12345678.
- Timeout, TIMEOUT=8: load with no response → mem_err=1 after exactly 8 WAIT_RESP cycles, a pending fetch is still issued and completes, and mem_err stays 1 until reset.
- Reset mid-WAIT_RESP: reset=0 for one edge, then a late mem_resp_valid with 0xFFFFFFFF → all outputs at reset values, rdata stays 0, FSM in IDLE.
- Input churn: change i_addr every cycle while stall=1 → the memory sees only the address captured in IDLE.
